// File: rtl/beef_pkg.sv
// Shared state type and constants for the beef program loader.
// Define BEEF_LOADER_CHECKSUM_EN to add the trailing checksum byte stage.
`timescale 1ns/1ps
package beef_pkg;

  localparam int BEEF_AW = 8;
  localparam int BEEF_IW = 9;
  localparam int BEEF_CW = 16;

  // Only bit 0 of a hi byte carries instruction data; bits 7:1 must be zero.
  localparam logic [7:0] HI_VALID_MASK = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_LO,
    ST_LOAD_HI,
`ifdef BEEF_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_RUN,
    ST_HALTED,
    ST_ERROR
  } loader_state_e;

  function automatic logic hiByteBad(input logic [7:0] b);
    return |(b & ~HI_VALID_MASK);
  endfunction

endpackage

// File: rtl/beef_prog_loader_if.sv
// Host byte stream, instruction RAM write port and CPU control seen by the loader.
// Checksum option BEEF_LOADER_CHECKSUM_EN does not change this interface.
`timescale 1ns/1ps
interface beef_prog_loader_if
  import beef_pkg::*;
#(
  parameter int AW = BEEF_AW,
  parameter int IW = BEEF_IW
);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          imem_we;
  logic          cpu_reset;
  logic          cpu_done;

  modport master (
    input  rx_data, rx_valid, cpu_done,
    output rx_ready, imem_addr, imem_wdata, imem_we, cpu_reset
  );

  modport slave (
    output rx_data, rx_valid, cpu_done,
    input  rx_ready, imem_addr, imem_wdata, imem_we, cpu_reset
  );

endinterface

// File: rtl/beef_byte_packer.sv
// Pairs a lo byte with the following hi byte into one instruction word and
// issues a one-cycle RAM write strobe; unaffected by BEEF_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module beef_byte_packer
  import beef_pkg::*;
#(
  parameter int AW = BEEF_AW,
  parameter int IW = BEEF_IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    i_byte,
  input  logic          i_lo_stb,
  input  logic          i_hi_stb,
  input  logic [AW-1:0] i_addr,
  output logic          o_hi_bad,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [IW-1:0] o_wdata
);

  logic [7:0]    r_lo;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [IW-1:0] r_wdata;
  logic          w_hi_bad;

  assign w_hi_bad = hiByteBad(i_byte);

  // The write lands one cycle after the hi byte, overlapping the next lo byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lo    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (i_lo_stb) begin
        r_lo <= i_byte;
      end
      if (i_hi_stb && !w_hi_bad) begin
        r_we    <= 1'b1;
        r_addr  <= i_addr;
        r_wdata <= IW'({i_byte[0], r_lo});
      end
    end
  end

  assign o_hi_bad = w_hi_bad;
  assign o_we     = r_we;
  assign o_addr   = r_addr;
  assign o_wdata  = r_wdata;

endmodule

// File: rtl/beef_prog_loader.sv
// Loads a host byte stream into instruction RAM, then releases the CPU until done.
// Define BEEF_LOADER_CHECKSUM_EN to require an XOR checksum byte before RUN.
`timescale 1ns/1ps
module beef_prog_loader
  import beef_pkg::*;
#(
  parameter int AW = BEEF_AW,
  parameter int IW = BEEF_IW,
  parameter int CW = BEEF_CW
) (
  input  logic              clk,
  input  logic              reset,
  beef_prog_loader_if.master bus,
  output logic              busy,
  output logic              error,
  output logic [CW-1:0]     run_cycles
);

  loader_state_e r_state;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_index;
  logic          r_rx_ready;
  logic          r_cpu_reset;
  logic          r_busy;
  logic          r_error;
  logic [CW-1:0] r_run_cycles;
`ifdef BEEF_LOADER_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  logic          w_accept;
  logic          w_lo_stb;
  logic          w_hi_stb;
  logic          w_hi_bad;
  logic          w_last;
  logic          w_imem_we;
  logic [AW-1:0] w_imem_addr;
  logic [IW-1:0] w_imem_wdata;

  assign w_accept = bus.rx_valid && r_rx_ready;
  assign w_lo_stb = w_accept && (r_state == ST_LOAD_LO);
  assign w_hi_stb = w_accept && (r_state == ST_LOAD_HI);
  assign w_last   = (r_index == r_len - AW'(1));

  beef_byte_packer #(.AW(AW), .IW(IW)) u_packer (
    .clk      (clk),
    .reset    (reset),
    .i_byte   (bus.rx_data),
    .i_lo_stb (w_lo_stb),
    .i_hi_stb (w_hi_stb),
    .i_addr   (r_index),
    .o_hi_bad (w_hi_bad),
    .o_we     (w_imem_we),
    .o_addr   (w_imem_addr),
    .o_wdata  (w_imem_wdata)
  );

  // The first RUN cycle keeps the CPU in reset so the final RAM write lands first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_index      <= '0;
      r_rx_ready   <= 1'b1;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_run_cycles <= '0;
`ifdef BEEF_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (bus.rx_data == 8'h00) begin
              r_state    <= ST_ERROR;
              r_rx_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= ST_LOAD_LO;
              r_len   <= AW'(bus.rx_data);
              r_index <= '0;
`ifdef BEEF_LOADER_CHECKSUM_EN
              r_csum  <= bus.rx_data;
`endif
            end
          end
        end
        ST_LOAD_LO: begin
          if (w_accept) begin
            r_state <= ST_LOAD_HI;
`ifdef BEEF_LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ bus.rx_data;
`endif
          end
        end
        ST_LOAD_HI: begin
          if (w_accept) begin
            if (w_hi_bad) begin
              r_state    <= ST_ERROR;
              r_rx_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_index <= r_index + AW'(1);
`ifdef BEEF_LOADER_CHECKSUM_EN
              r_csum  <= r_csum ^ bus.rx_data;
`endif
              if (w_last) begin
`ifdef BEEF_LOADER_CHECKSUM_EN
                r_state      <= ST_CHECK;
`else
                r_state      <= ST_RUN;
                r_rx_ready   <= 1'b0;
                r_run_cycles <= '0;
`endif
              end else begin
                r_state <= ST_LOAD_LO;
              end
            end
          end
        end
`ifdef BEEF_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            if (bus.rx_data == r_csum) begin
              r_state      <= ST_RUN;
              r_run_cycles <= '0;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        ST_RUN: begin
          if (r_run_cycles != '1) begin
            r_run_cycles <= r_run_cycles + CW'(1);
          end
          if (bus.cpu_done) begin
            r_state     <= ST_HALTED;
            r_cpu_reset <= 1'b1;
            r_rx_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cpu_reset <= 1'b0;
          end
        end
        ST_ERROR: begin
        end
        default: begin
          r_state     <= ST_ERROR;
          r_rx_ready  <= 1'b0;
          r_cpu_reset <= 1'b1;
          r_busy      <= 1'b1;
          r_error     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rx_ready   = r_rx_ready;
  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.imem_we    = w_imem_we;
  assign bus.imem_addr  = w_imem_addr;
  assign bus.imem_wdata = w_imem_wdata;
  assign busy           = r_busy;
  assign error          = r_error;
  assign run_cycles     = r_run_cycles;

endmodule
